// File: rtl/ex_stage_pipe.sv
// Registered execute stage: ALU, branch target and write-back index behind valid/ready handshakes.
// Define EX_MUL_EN to add the iterative shift-add multiplier (funct 011000, XLEN-cycle latency).
module ex_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [XLEN-1:0]       read_data1,
    input  logic [XLEN-1:0]       read_data2,
    input  logic [XLEN-1:0]       sign_extended,
    input  logic [REG_ADDR_W-1:0] rt,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  RegDst,
    input  logic                  ALUSrc,
    input  logic [1:0]            ALUOp,
    input  logic [5:0]            funct,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       alu_result,
    output logic                  zero,
    output logic [XLEN-1:0]       branch_addr,
    output logic [REG_ADDR_W-1:0] reg_dst,
    output logic                  busy
);

    logic [XLEN-1:0]       op_b;
    logic [XLEN-1:0]       alu_comb;
    logic [XLEN-1:0]       branch_comb;
    logic [REG_ADDR_W-1:0] dst_comb;
    logic                  out_free;
    logic                  accept;

    assign op_b        = ALUSrc ? sign_extended : read_data2;
    assign branch_comb = pc_plus4 + (sign_extended << 2);
    assign dst_comb    = RegDst ? rd : rt;
    assign out_free    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;

`ifdef EX_MUL_EN
    // IDLE: accepting ops | MUL: shift-add running, cnt = steps left after this one
    typedef enum logic {IDLE, MUL} state_t;
    localparam int CNT_W = $clog2(XLEN);

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic            busy_q;
    logic            is_mult;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign in_ready = (state == IDLE) && out_free && !flush;
    assign busy     = busy_q;
`else
    assign in_ready = out_free && !flush;
    assign busy     = 1'b0;
`endif

    always_comb begin
        alu_comb = '0;
`ifdef EX_MUL_EN
        is_mult = 1'b0;
`endif
        case (ALUOp)
            2'b00: alu_comb = read_data1 + op_b;
            2'b01: alu_comb = read_data1 - op_b;
            2'b11: alu_comb = read_data1 | op_b;
            default: begin
                case (funct)
                    6'b100000: alu_comb = read_data1 + op_b;
                    6'b100010: alu_comb = read_data1 - op_b;
                    6'b100100: alu_comb = read_data1 & op_b;
                    6'b100101: alu_comb = read_data1 | op_b;
                    6'b100111: alu_comb = ~(read_data1 | op_b);
                    6'b101010: alu_comb = {{(XLEN-1){1'b0}}, ($signed(read_data1) < $signed(op_b))};
`ifdef EX_MUL_EN
                    6'b011000: is_mult = 1'b1;
`endif
                    default:   alu_comb = '0;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            alu_result  <= '0;
            zero        <= 1'b0;
            branch_addr <= '0;
            reg_dst     <= '0;
`ifdef EX_MUL_EN
            state  <= IDLE;
            busy_q <= 1'b0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
`ifdef EX_MUL_EN
            state  <= IDLE;
            busy_q <= 1'b0;
`endif
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                branch_addr <= branch_comb;
                reg_dst     <= dst_comb;
`ifdef EX_MUL_EN
                if (is_mult) begin
                    mcand  <= read_data1;
                    mplier <= op_b;
                    acc    <= '0;
                    cnt    <= CNT_W'(XLEN - 1);
                    state  <= MUL;
                    busy_q <= 1'b1;
                end else
`endif
                begin
                    alu_result <= alu_comb;
                    zero       <= (alu_comb == '0);
                    out_valid  <= 1'b1;
                end
            end
`ifdef EX_MUL_EN
            // Last step folds its partial product straight into the output register
            if (state == MUL) begin
                if (cnt == '0) begin
                    alu_result <= acc_next;
                    zero       <= (acc_next == '0);
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                    busy_q     <= 1'b0;
                end else begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: doc/ex_stage_pipe.md
# ex_stage_pipe

Parametrised, registered execute stage with valid/ready handshakes on both sides, sitting between the ID/EX register and the MEM stage. It decodes ALUOp/funct internally, computes the ALU result, zero flag, branch target and write-back register, and captures them in an output register. An optional iterative multiplier gives a multi-cycle MULT path, which back-pressures ID while it runs.

## Interface
Parameters:
- XLEN, 32, datapath width (≥8)
- REG_ADDR_W, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous kill of the in-flight/held op
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage can accept (combinational)
- pc_plus4  in  XLEN  PC+4 of op
- read_data1  in  XLEN  operand A
- read_data2  in  XLEN  operand B (register)
- sign_extended  in  XLEN  immediate
- rt  in  REG_ADDR_W  rt index
- rd  in  REG_ADDR_W  rd index
- RegDst  in  1  1 → rd, 0 → rt
- ALUSrc  in  1  1 → immediate as operand B
- ALUOp  in  2  00 add, 01 sub, 10 R-type by funct, 11 or
- funct  in  6  R-type function code
- out_valid  out  1  output register holds a result
- out_ready  in  1  downstream accepts
- alu_result  out  XLEN  registered result
- zero  out  1  registered (alu_result == 0)
- branch_addr  out  XLEN  registered pc_plus4 + (sign_extended << 2)
- reg_dst  out  REG_ADDR_W  registered destination index
- busy  out  1  multiplier running

## Operation
- Funct decode for ALUOp=10: 100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt (signed, result 1/0), 011000 mult (macro-dependent). Any other funct gives result 0.
- Arithmetic is modulo 2^XLEN, with no overflow trap. branch_addr uses the shifted immediate truncated to XLEN bits.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- State IDLE, accepting a single-cycle op: load the output register at that edge and set out_valid=1.
- State IDLE, accepting a mult: latch the operands, reg_dst and branch_addr, then go to MUL with cnt=XLEN-1 and busy=1. out_valid clears at that edge if the previous result was consumed.
- State MUL: one shift-add step per cycle. When cnt==0, load the low XLEN product bits into alu_result, compute zero, set out_valid=1 and return to IDLE.
- Output hold: while out_valid && !out_ready, all outputs are stable.
- Output release: out_valid drops when out_ready is high and no new result is loaded that edge.
- Back-to-back ops: an accept coincident with out_ready replaces the output register. out_valid stays high.
- flush: at the next edge, clear out_valid, abort MUL to IDLE and drop busy. flush has priority over accept and completion in the same cycle.
- reset: out_valid=0, busy=0, state=IDLE, cnt=0, and alu_result, branch_addr, reg_dst, zero all 0.
  - Reset takes effect immediately, including mid-MUL.
  - in_ready becomes 1 after reset deasserts, provided flush is low.

## Timing
- Single-cycle op: accepted at edge N, out_valid high after edge N. Latency 1.
- Throughput 1 op/cycle while out_ready is held high.
- Mult: accepted at edge N, result and out_valid high after edge N+XLEN. in_ready is low for cycles N+1 to N+XLEN.
- zero is registered together with alu_result, never from a later cycle.

## Configuration
- EX_MUL_EN defined: mult (funct 011000) uses the MUL state, latency XLEN, busy as above.
- EX_MUL_EN undefined: no multiplier logic and no MUL state. funct 011000 is an undecoded op: result 0, zero=1, single-cycle. busy is tied 0.

## Test plan
- Reset/idle: reset pulsed mid-operation → all outputs 0, out_valid=0, in_ready=1 after release.
- ALU ops, one per cycle with out_ready=1:
  - R-type add 5+7 → alu_result=12, zero=0.
  - sub 9-9 → 0, zero=1.
  - slt -1<1 → 1.
  - ALUSrc=1 with imm 0xFFFFFFFC and A=8 → 4.
  - RegDst=0 → reg_dst=rt.
  - pc_plus4=0x100 with imm=-1 → branch_addr=0xFC.
- Back-pressure: out_ready=0 with a result held → outputs stable for 5 cycles and in_ready=0. Raising out_ready releases the result and the next op loads the following cycle.
- Mult (EX_MUL_EN): 0x0001_0003 × 0x0000_0005 → 0x0005_000F after exactly XLEN cycles. in_ready=0 and busy=1 throughout. 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Flush: flush during MUL cycle 10 → busy=0 and out_valid=0 the next cycle, no result emitted. flush coincident with in_valid → op not accepted.
- Macro off: funct 011000 → alu_result=0 and zero=1 with 1-cycle latency, busy stays 0.
